// File: rtl/mult32_seq.sv
// mult32_seq: sequential shift-add multiplier, one product bit per clock.
// A WIDTH x WIDTH multiply takes WIDTH BUSY cycles, followed by a one-cycle
// done pulse. The product stays on prod_hi/prod_lo until the next result
// is written.
// Optional feature: define MULT32_SIGNED_EN for two's complement operands.
// Magnitudes are multiplied and the result is negated when the signs differ,
// so latency is the same as in the unsigned build.
module mult32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi
);

  // Counter only ever has to reach WIDTH-1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand;     // captured multiplicand
  logic [2*WIDTH-1:0] acc;       // {partial product, remaining multiplier bits}
  logic [CW-1:0]      count;     // steps already performed
  logic               accept;    // start is honoured in this cycle
  logic               last;      // this edge performs the final step
  logic [WIDTH:0]     sum;       // upper half plus optional multiplicand, with carry
  logic [2*WIDTH-1:0] acc_step;  // accumulator after one shift-add step
  logic [2*WIDTH-1:0] result;    // value written to the product outputs
  logic [WIDTH-1:0]   a_op, b_op;

`ifdef MULT32_SIGNED_EN
  logic neg;  // operand signs differ, so the final product is negated

  // Reduce the operands to magnitudes; -MIN is MIN, which is correct unsigned.
  always_comb begin
    a_op = a[WIDTH-1] ? -a : a;
    b_op = b[WIDTH-1] ? -b : b;
  end

  // Apply the sign on the final step so that latency is unchanged.
  always_comb result = neg ? -acc_step : acc_step;
`else
  // Operands are used as given.
  always_comb begin
    a_op = a;
    b_op = b;
  end

  // The unsigned product is taken straight from the accumulator.
  always_comb result = acc_step;
`endif

  // Qualify start and detect the final step.
  always_comb begin
    accept = start && (state == IDLE || state == DONE);
    last   = (state == BUSY) && (count == CW'(WIDTH - 1));
  end

  // One shift-add step: conditionally add, then shift {carry, acc} right.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_step = {sum, acc[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, stepping and product write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      acc     <= '0;
      count   <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
`ifdef MULT32_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else if (accept) begin
      mcand <= a_op;
      acc   <= {{WIDTH{1'b0}}, b_op};
      count <= '0;
`ifdef MULT32_SIGNED_EN
      neg   <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
    end else if (state == BUSY) begin
      acc <= acc_step;
      if (last) {prod_hi, prod_lo} <= result;
      else      count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mult32_seq.sv
// tb_mult32_seq: directed vectors with hand-computed products for mult32_seq.
// The expected values follow MULT32_SIGNED_EN so one bench covers both builds.
module tb_mult32_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] prod_lo, prod_hi;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  mult32_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .prod_lo(prod_lo), .prod_hi(prod_hi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Count one comparison and report it if it differs.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Call at a negedge. Pulses start for one edge and then waits for done.
  // lat counts negedges from the one after the accepting edge to done; it
  // should be 33. nbusy counts the cycles in which busy was high.
  task automatic mul(input logic [31:0] x, input logic [31:0] y,
                     output logic [63:0] p, output int lat, output int nbusy);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~x; b = ~y;  // later operand changes must not matter
    lat = 1; nbusy = 0;
    while (!done && lat < 100) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    p = {prod_hi, prod_lo};
  endtask

  logic [63:0] p;
  int lat, nb, ndone, t1, t2;

  initial begin
    // Reset is asserted at time 0.
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_prod", {prod_hi, prod_lo}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // 3 * 5: latency, busy length, single-cycle done, and the product hold.
    mul(32'd3, 32'd5, p, lat, nb);
    chk("3x5_prod", p, 64'h0000_0000_0000_000F);
    chk("3x5_latency", 64'(lat), 64'd33);
    chk("3x5_busy_cycles", 64'(nb), 64'd32);
    chk("3x5_done_busy_excl", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("3x5_done_one_cycle", {63'd0, done}, 64'd0);
    repeat (3) @(negedge clk);
    chk("3x5_hold", {prod_hi, prod_lo}, 64'h0000_0000_0000_000F);

    // All-ones operands.
    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat, nb);
`ifdef MULT32_SIGNED_EN
    chk("ones_prod", p, 64'h0000_0000_0000_0001);
`else
    chk("ones_prod", p, 64'hFFFF_FFFE_0000_0001);
`endif
    @(negedge clk);

    // The carry out of the upper half must be kept.
    mul(32'h8000_0000, 32'd2, p, lat, nb);
`ifdef MULT32_SIGNED_EN
    chk("msb_x2_prod", p, 64'hFFFF_FFFF_0000_0000);
`else
    chk("msb_x2_prod", p, 64'h0000_0001_0000_0000);
`endif
    @(negedge clk);
    mul(32'h0001_0000, 32'h0001_0000, p, lat, nb);
    chk("2p16_sq_prod", p, 64'h0000_0001_0000_0000);
    @(negedge clk);
    mul(32'hFFFF_FFFF, 32'd1, p, lat, nb);
`ifdef MULT32_SIGNED_EN
    chk("ones_x1_prod", p, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    chk("ones_x1_prod", p, 64'h0000_0000_FFFF_FFFF);
`endif
    @(negedge clk);
`ifdef MULT32_SIGNED_EN
    mul(32'hFFFF_FFFE, 32'd7, p, lat, nb);
    chk("m2x7_prod", p, 64'hFFFF_FFFF_FFFF_FFF2);
    @(negedge clk);
`endif

    // A start raised while BUSY is ignored: 2 * 2, with 9 * 9 offered at step 10.
    a = 32'd2; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 32'hDEAD_BEEF; lat = 1;
    repeat (9) begin @(negedge clk); lat++; end
    a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk); lat++;
    start = 1'b0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    chk("ignore_latency", 64'(lat), 64'd33);
    chk("ignore_prod", {prod_hi, prod_lo}, 64'd4);
    @(negedge clk);

    // Reset during BUSY clears everything at once, and no done follows.
    a = 32'd6; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_prod", {prod_hi, prod_lo}, 64'd0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    // The first edge after reset is released accepts start.
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    mul(32'd6, 32'd7, p, lat, nb);
    chk("post_rst_prod", p, 64'h2A);
    chk("post_rst_latency", 64'(lat), 64'd33);
    @(negedge clk);

    // Holding start high across DONE starts the next multiply back-to-back.
    a = 32'd4; b = 32'd4; start = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    t1 = cyc;
    chk("b2b_first_prod", {prod_hi, prod_lo}, 64'h10);
    @(negedge clk);
    chk("b2b_no_idle", {63'd0, busy}, 64'd1);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    t2 = cyc;
    chk("b2b_spacing", 64'(t2 - t1), 64'd33);
    chk("b2b_second_prod", {prod_hi, prod_lo}, 64'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
